// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Iterative multiply/divide unit for the mMIPS core.
//                Executes MULT, MULTU, DIV and DIVU one bit per clock and
//                writes the result into the HI/LO registers read by MFHI/MFLO.
//                A start/busy/done handshake lets the pipeline stall on busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_div0;
  logic               r_neg_q;    // quotient / product must be negated
  logic               r_neg_r;    // remainder takes the dividend's sign
  logic [WIDTH-1:0]   r_acc;      // product upper half / partial remainder
  logic [WIDTH-1:0]   r_q;        // multiplier / dividend shifting out, result shifting in
  logic [WIDTH-1:0]   r_b;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_z;

  // Operand capture: signed ops work on magnitudes and remember the signs
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  // One iteration of each algorithm
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]   w_q_step;

  // Sign-corrected final result
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_step   = (r_state == S_CALC) && !abort;
  assign w_last   = w_step && (r_cnt == C_CNT_LAST);

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIX);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign z    = r_z;

  // Shift-add multiply and restoring shift-subtract divide step
  always_comb begin
    w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_div_sh   = {r_acc, r_q[WIDTH-1]};
    w_div_ok   = (w_div_sh >= {1'b0, r_b});
    w_div_diff = w_div_sh[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_acc_step = w_div_ok ? w_div_diff : w_div_sh[WIDTH-1:0];
      w_q_step   = {r_q[WIDTH-2:0], w_div_ok};
    end else begin
      w_acc_step = w_mul_sum[WIDTH:1];
      w_q_step   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end
  end

  // Sign correction; divide by zero leaves the remainder equal to a
  always_comb begin
    w_prod     = {w_acc_step, w_q_step};
    w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    if (r_is_div) begin
      w_lo_fin = r_div0  ? '1 : (r_neg_q ? (~w_q_step + 1'b1) : w_q_step);
      w_hi_fin = r_neg_r ? (~w_acc_step + 1'b1) : w_acc_step;
    end else begin
      w_lo_fin = w_prod_fix[WIDTH-1:0];
      w_hi_fin = w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort only matters while iterating
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_CALC;
      S_CALC: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and HI/LO write on the final step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_z      <= 1'b1;
    end else if (w_accept) begin
      r_cnt    <= C_CNT_INIT;
      r_is_div <= op[1];
      r_div0   <= (b == '0);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_acc    <= '0;
      r_q      <= w_a_mag;
      r_b      <= w_b_mag;
    end else if (w_step) begin
      r_cnt <= r_cnt - 1'b1;
      r_acc <= w_acc_step;
      r_q   <= w_q_step;
      if (w_last) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
        r_z  <= ({w_hi_fin, w_lo_fin} == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Self-checking bench for alu_muldiv_seq (WIDTH=32): directed
//                vector table, handshake corner cases, and random operations
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          abort;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          z;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo), .z(z)
  );

  // Free-running clock
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the MIPS definitions, returns {hi,lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'h0, x};
    longint unsigned uy = {32'h0, y};
    longint          sq;
    longint          sr;
    logic [63:0]     res;
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = ux * uy;
      2'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          sq  = sx / sy;
          sr  = sx % sy;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Issue one op, scramble inputs while busy, count edges from the accepting edge to done
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output int lat, output bit one_pulse);
    @(negedge clock);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    lat = -1;
    one_pulse = 1'b0;
    for (int k = 2; k <= 100; k++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clock); #1;
      one_pulse = !done && !busy;
    end
  endtask

  vec_t        vecs[9];
  int          lat;
  bit          pulse;
  int          ndone;
  logic [63:0] exp;
  logic [63:0] prev;
  logic [1:0]  ro;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    clock = 0; reset = 1; start = 0; abort = 0; op = 0; a = 0; b = 0;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{2'd1, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_z", 64'(z), 64'd1);
    @(negedge clock); reset = 0;

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, pulse);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_pulse", i), 64'(pulse), 64'd1);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_z", i), 64'(z), 64'(vecs[i].z));
    end

    // start pulses at cycles 5 and 20 and during FIX are ignored
    @(negedge clock);
    op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 2; k <= 45; k++) begin
      @(negedge clock);
      start = (k == 5 || k == 20 || k == 34);
      if (start) begin op = 2'd1; a = $urandom; b = $urandom; end
      @(posedge clock); #1;
      if (done) ndone++;
      if (k == 34) check("fix_start_ignored_busy", 64'(busy), 64'd0);
    end
    start = 1'b0;
    check("ignored_start_done_count", 64'(ndone), 64'd1);
    check("ignored_start_result", {hi, lo}, {32'd6, 32'd142});

    // start together with abort in IDLE: start wins
    @(negedge clock);
    op = 2'd0; a = 32'hFFFF_FFF6; b = 32'd3; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd1);
    lat = -1;
    for (int k = 2; k <= 100; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k; break; end
    end
    check("start_abort_latency", 64'(lat), 64'd33);
    check("start_abort_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

    // abort at cycle 10: no done, HI/LO untouched
    prev = {hi, lo};
    @(negedge clock);
    op = 2'd1; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 2; k <= 45; k++) begin
      @(negedge clock);
      abort = (k == 10);
      @(posedge clock); #1;
      if (done) ndone++;
      if (k == 10) check("abort_busy_drop", 64'(busy), 64'd0);
    end
    abort = 1'b0;
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hilo_kept", {hi, lo}, prev);

    // asynchronous reset mid-operation
    @(negedge clock);
    op = 2'd2; a = 32'd999; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    check("async_reset_z", 64'(z), 64'd1);
    @(negedge clock); reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check("async_reset_no_done", 64'(ndone), 64'd0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      exp = model(ro, ra, rb);
      run_op(ro, ra, rb, lat, pulse);
      check($sformatf("rand%0d_op%0d_%h_%h_latency", i, ro, ra, rb), 64'(lat), 64'd33);
      check($sformatf("rand%0d_op%0d_%h_%h_hilo", i, ro, ra, rb), {hi, lo}, exp);
      check($sformatf("rand%0d_z", i), 64'(z), 64'(exp == 64'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
